// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download scheduler: region map, FSM states and
// the FIFO entry layout.
package rom_dl_pkg;

  typedef enum logic [1:0] {
    RGN_CPU  = 2'd0,
    RGN_SND  = 2'd1,
    RGN_GFX  = 2'd2,
    RGN_PROM = 2'd3
  } region_e;

  localparam logic [15:0] CPU_BASE   = 16'h0000;
  localparam logic [15:0] CPU_LIMIT  = 16'h7FFF;
  localparam logic [15:0] SND_BASE   = 16'h8000;
  localparam logic [15:0] SND_LIMIT  = 16'h9FFF;
  localparam logic [15:0] GFX_BASE   = 16'hA000;
  localparam logic [15:0] GFX_LIMIT  = 16'hDFFF;
  localparam logic [15:0] PROM_BASE  = 16'hE000;
  localparam logic [15:0] PROM_LIMIT = 16'hE1FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // The offset field has to span the whole 32 KiB CPU region.
  typedef struct packed {
    region_e     region;
    logic [14:0] offset;
    logic [7:0]  data;
  } dl_entry_t;

  localparam int ENTRY_W = $bits(dl_entry_t);

  function automatic region_e region_of(input logic [15:0] addr);
    region_e r;
    if (addr <= CPU_LIMIT)      r = RGN_CPU;
    else if (addr <= SND_LIMIT) r = RGN_SND;
    else if (addr <= GFX_LIMIT) r = RGN_GFX;
    else                        r = RGN_PROM;
    return r;
  endfunction

  function automatic logic [15:0] region_base(input region_e r);
    logic [15:0] b;
    case (r)
      RGN_CPU:  b = CPU_BASE;
      RGN_SND:  b = SND_BASE;
      RGN_GFX:  b = GFX_BASE;
      default:  b = PROM_BASE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Small first-word-fall-through FIFO for pending download writes; the head
// entry is visible combinationally so a write into an empty FIFO shows next cycle.
module dl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // Pointers carry one extra wrap bit to tell full from empty.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rom_dl_sched.sv
// ROM download scheduler: routes download bytes to region memories and holds
// the core in reset. Optional running checksum enabled by DL_CHECKSUM_EN.
module rom_dl_sched
  import rom_dl_pkg::*;
#(
  parameter int RST_HOLD   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic [3:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  input  logic        rom_ready,
  output logic        core_reset,
  output logic        dl_done,
  output logic        err_ovf,
  output logic        err_oob,
  output logic [7:0]  checksum
);

  localparam int HCW = $clog2(RST_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_HOLD - 1);

  state_e           state;
  logic             act_reg;
  logic [HCW-1:0]   hold_cnt;
  logic             act_rise;
  logic             in_bounds;
  logic             wr_req;
  logic             push;
  logic             pop;
  logic             wr_oob;
  logic             wr_ovf;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  dl_entry_t        wr_entry;
  dl_entry_t        head;
  logic [15:0]      offset_full;

  assign act_rise  = dl_active & ~act_reg;
  assign in_bounds = (dl_addr <= PROM_LIMIT);
  assign wr_req    = (state == ST_LOAD) && dl_wr;
  assign pop       = !fifo_empty && rom_ready;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push      = wr_req && in_bounds && (!fifo_full || pop);
  assign wr_oob    = wr_req && !in_bounds;
  assign wr_ovf    = wr_req && in_bounds && fifo_full && !pop;

  always_comb begin
    wr_entry        = '0;
    wr_entry.region = region_of(dl_addr);
    offset_full     = dl_addr - region_base(wr_entry.region);
    wr_entry.offset = offset_full[14:0];
    wr_entry.data   = dl_data;
  end

  dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     (wr_entry),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head = dl_entry_t'(fifo_dout);

  for (genvar gi = 0; gi < 4; gi++) begin : g_we
    assign rom_we[gi] = !fifo_empty && (head.region == region_e'(gi));
  end

  assign rom_addr   = fifo_empty ? 16'h0000 : {1'b0, head.offset};
  assign rom_data   = fifo_empty ? 8'h00 : head.data;
  assign core_reset = reset | (state != ST_IDLE);

  // act_reg resets high so a session left active across reset must drop first.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      act_reg  <= 1'b1;
      hold_cnt <= '0;
      dl_done  <= 1'b0;
      err_ovf  <= 1'b0;
      err_oob  <= 1'b0;
    end else begin
      act_reg <= dl_active;
      dl_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (act_rise) begin
            state   <= ST_LOAD;
            err_ovf <= 1'b0;
            err_oob <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (wr_oob) err_oob <= 1'b1;
          if (wr_ovf) err_ovf <= 1'b1;
          if (!dl_active) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        default: begin
          if (act_rise) begin
            state    <= ST_LOAD;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state   <= ST_IDLE;
            dl_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
      endcase
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [7:0] sum_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_reg <= 8'h00;
    end else if (state == ST_IDLE && act_rise) begin
      sum_reg <= 8'h00;
    end else if (pop) begin
      sum_reg <= sum_reg + rom_data;
    end
  end

  assign checksum = sum_reg;
`else
  assign checksum = 8'h00;
`endif

endmodule
